ulaplus_pixel: RTL and testbench

- Video-side consumer of the ULAplus palette.
- Takes bitmap and attribute bytes from the ULA fetch logic and drives the palette lookup addresses (ink_addr/paper_addr).
- Samples the returned palette entries and serialises one GRB332 pixel per pixel strobe.
- In classic mode the block produces the standard Spectrum colours itself, including BRIGHT and FLASH, without using the palette.

---
 rtl/ulaplus_pixel.sv | 106 ++++++++++
 tb/tb_ulaplus_pixel.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ulaplus_pixel.sv
// ULAplus video pixel stage: latches bitmap/attr per pixel strobe, drives palette
// addresses, and emits one GRB332 pixel per strobe (palette or classic colours).
module ulaplus_pixel #(
    parameter int FLASH_FRAMES = 16
) (
    input  logic       clk28,
    input  logic       rst_n,
    input  logic       ulaplus_en,
    input  logic       pix_strobe,
    input  logic       pix_load,
    input  logic [7:0] bitmap,
    input  logic [7:0] attr,
    input  logic       border,
    input  logic [2:0] border_color,
    input  logic       blank,
    input  logic       frame_strobe,
    output logic [5:0] ink_addr,
    output logic [5:0] paper_addr,
    input  logic [7:0] ink,
    input  logic [7:0] paper,
    output logic [7:0] rgb
);
    localparam int CW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    logic [7:0]    shift;
    logic [7:0]    attr_reg;
    logic          cur_bit;
    logic          cur_border;
    logic [2:0]    cur_border_color;
    logic          cur_blank;
    logic [CW-1:0] flash_cnt;
    logic          flash_phase;

    logic [7:0]    attr_nxt;
    logic [7:0]    pix_color;
    logic          bit_eff;
    logic          bright;
    logic [2:0]    idx;
    logic [2:0]    lvl;

    // Addresses track the attribute that will be current after this strobe.
    assign attr_nxt = pix_load ? attr : attr_reg;

    always_comb begin
        pix_color = 8'h00;
        bit_eff   = cur_bit ^ (attr_reg[7] & flash_phase);
        bright    = attr_reg[6] & ~cur_border;
        lvl       = bright ? 3'b111 : 3'b101;
        idx       = cur_border ? cur_border_color
                               : (bit_eff ? attr_reg[2:0] : attr_reg[5:3]);
        if (cur_blank)
            pix_color = 8'h00;
        else if (ulaplus_en)
            pix_color = (!cur_border && cur_bit) ? ink : paper;
        else
            pix_color = {idx[2] ? lvl : 3'b000,
                         idx[1] ? lvl : 3'b000,
                         idx[0] ? {1'b1, bright} : 2'b00};
    end

    always_ff @(posedge clk28) begin
        if (!rst_n) begin
            rgb              <= 8'h00;
            ink_addr         <= 6'h00;
            paper_addr       <= 6'h00;
            shift            <= 8'h00;
            attr_reg         <= 8'h00;
            cur_bit          <= 1'b0;
            cur_border       <= 1'b0;
            cur_border_color <= 3'b000;
            cur_blank        <= 1'b0;
            flash_cnt        <= '0;
            flash_phase      <= 1'b0;
        end else begin
            if (frame_strobe) begin
                if (flash_cnt == CW'(FLASH_FRAMES - 1)) begin
                    flash_cnt   <= '0;
                    flash_phase <= ~flash_phase;
                end else begin
                    flash_cnt <= flash_cnt + 1'b1;
                end
            end
            if (pix_strobe) begin
                // Stage 2 samples the pixel held in stage 1 before it advances.
                rgb <= pix_color;
                if (pix_load) begin
                    attr_reg <= attr;
                    cur_bit  <= bitmap[7];
                    shift    <= {bitmap[6:0], 1'b0};
                end else begin
                    cur_bit <= shift[7];
                    shift   <= {shift[6:0], 1'b0};
                end
                cur_border       <= border;
                cur_border_color <= border_color;
                cur_blank        <= blank;
                if (border) begin
                    paper_addr <= {3'b001, border_color};
                end else begin
                    ink_addr   <= {attr_nxt[7:6], 1'b0, attr_nxt[2:0]};
                    paper_addr <= {attr_nxt[7:6], 1'b1, attr_nxt[5:3]};
                end
            end
        end
    end
endmodule

// File: tb/tb_ulaplus_pixel.sv
// Scoreboard bench for ulaplus_pixel: stimulus queues expected pixels, a monitor
// compares each one at the following pix_strobe.
module tb_ulaplus_pixel;
    logic       clk28 = 1'b0;
    logic       rst_n, ulaplus_en, pix_strobe, pix_load, border, blank, frame_strobe;
    logic [7:0] bitmap, attr, ink, paper, rgb;
    logic [2:0] border_color;
    logic [5:0] ink_addr, paper_addr;
    logic [7:0] pal [64];

    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        bit         chk;
        logic [7:0] exp;
        int         id;
    } ent_t;

    ent_t q[$];
    ent_t prev;
    bit   have_prev = 0;
    int   pix_id = 0;

    always #5 clk28 = ~clk28;

    assign ink   = pal[ink_addr];
    assign paper = pal[paper_addr];

    ulaplus_pixel #(.FLASH_FRAMES(2)) dut (
        .clk28(clk28), .rst_n(rst_n), .ulaplus_en(ulaplus_en),
        .pix_strobe(pix_strobe), .pix_load(pix_load), .bitmap(bitmap), .attr(attr),
        .border(border), .border_color(border_color), .blank(blank),
        .frame_strobe(frame_strobe), .ink_addr(ink_addr), .paper_addr(paper_addr),
        .ink(ink), .paper(paper), .rgb(rgb)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    // Monitor: each strobe presents the colour of the pixel issued one strobe earlier.
    always @(posedge clk28) begin
        if (!rst_n) begin
            have_prev = 0;
        end else if (pix_strobe) begin
            #1;
            if (have_prev && prev.chk)
                check($sformatf("rgb_pix%0d", prev.id), rgb, prev.exp);
            if (q.size() == 0) begin
                check("scoreboard_empty", 8'h01, 8'h00);
                have_prev = 0;
            end else begin
                prev      = q.pop_front();
                have_prev = 1;
            end
        end
    end

    // One pixel: a strobe cycle then three idle cycles carrying junk that must be ignored.
    task automatic pixel(input bit ld, input logic [7:0] bmp, input logic [7:0] at,
                         input bit brd, input logic [2:0] bc, input bit blk,
                         input bit fr, input bit chk, input logic [7:0] exp);
        ent_t e;
        @(negedge clk28);
        e.chk = chk; e.exp = exp; e.id = pix_id++;
        q.push_back(e);
        pix_strobe = 1'b1; pix_load = ld; bitmap = bmp; attr = at;
        border = brd; border_color = bc; blank = blk; frame_strobe = fr;
        @(negedge clk28);
        pix_strobe = 1'b0; pix_load = 1'b1; bitmap = ~bmp; attr = 8'h3C;
        border = 1'b1; border_color = 3'd2; blank = 1'b1; frame_strobe = 1'b0;
        repeat (2) @(negedge clk28);
    endtask

    task automatic px_load(input logic [7:0] bmp, input logic [7:0] at, input logic [7:0] exp);
        pixel(1'b1, bmp, at, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, exp);
    endtask

    task automatic px_shift(input logic [7:0] exp);
        pixel(1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, exp);
    endtask

    task automatic px_fr(input bit fr, input logic [7:0] exp);
        pixel(1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, fr, 1'b1, exp);
    endtask

    task automatic px_blank();
        pixel(1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 8'h00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) pal[i] = 8'(i * 4 + 1);
        pal[6'h31] = 8'hE0;
        pal[6'h38] = 8'h1C;
        pal[6'h0D] = 8'h5A;

        rst_n = 1'b0; ulaplus_en = 1'b0; pix_strobe = 1'b0; pix_load = 1'b0;
        bitmap = 8'h00; attr = 8'h00; border = 1'b0; border_color = 3'd0;
        blank = 1'b0; frame_strobe = 1'b0;
        repeat (3) @(negedge clk28);
        check("reset_rgb", rgb, 8'h00);
        check("reset_ink_addr", {2'b00, ink_addr}, 8'h00);
        check("reset_paper_addr", {2'b00, paper_addr}, 8'h00);
        rst_n = 1'b1;

        // Classic: bright white ink, one set bit then black paper.
        px_load(8'h80, 8'h47, 8'hFF);
        repeat (7) px_shift(8'h00);

        // Classic: red ink on blue paper, alternating bits.
        px_load(8'h55, 8'h0A, 8'h02);
        for (int i = 1; i < 8; i++) px_shift((i % 2) ? 8'h14 : 8'h02);
        px_blank();

        // Palette mode.
        ulaplus_en = 1'b1;
        px_load(8'hF0, 8'hC1, 8'hE0);
        check("pal_ink_addr", {2'b00, ink_addr}, 8'h31);
        check("pal_paper_addr", {2'b00, paper_addr}, 8'h38);
        repeat (3) px_shift(8'hE0);
        repeat (4) px_shift(8'h1C);

        // Border in palette mode uses CLUT0 paper; ink address holds.
        pixel(1'b0, 8'h00, 8'h00, 1'b1, 3'd5, 1'b0, 1'b0, 1'b1, 8'h5A);
        check("border_paper_addr", {2'b00, paper_addr}, 8'h0D);
        check("border_ink_addr_held", {2'b00, ink_addr}, 8'h31);
        px_blank();
        ulaplus_en = 1'b0;
        // Classic border colour 5 (G+B), never bright even with BRIGHT attr latched.
        pixel(1'b0, 8'h00, 8'h00, 1'b1, 3'd5, 1'b0, 1'b0, 1'b1, 8'hA2);
        pixel(1'b0, 8'h00, 8'h00, 1'b1, 3'd5, 1'b1, 1'b0, 1'b1, 8'h00);

        // FLASH with FLASH_FRAMES=2: phase toggles on every second frame strobe.
        px_load(8'hFF, 8'h87, 8'hB6);
        px_fr(1'b1, 8'hB6);
        px_fr(1'b1, 8'h00);
        px_fr(1'b1, 8'h00);
        px_fr(1'b1, 8'hB6);
        px_fr(1'b0, 8'hB6);
        px_fr(1'b1, 8'hB6);
        px_fr(1'b1, 8'h00);
        px_blank();
        // Phase is now inverted; palette mode must ignore it.
        ulaplus_en = 1'b1;
        px_load(8'hFF, 8'h87, 8'h9D);
        check("flash_pal_ink_addr", {2'b00, ink_addr}, 8'h27);
        px_shift(8'h9D);
        px_blank();
        ulaplus_en = 1'b0;

        // Reset mid-byte.
        pixel(1'b1, 8'hF0, 8'h47, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00);
        px_shift(8'hFF);
        rst_n = 1'b0;
        @(negedge clk28);
        check("midreset_rgb", rgb, 8'h00);
        check("midreset_ink_addr", {2'b00, ink_addr}, 8'h00);
        check("midreset_paper_addr", {2'b00, paper_addr}, 8'h00);
        rst_n = 1'b1;
        px_shift(8'h00);
        px_load(8'h80, 8'h47, 8'hFF);
        px_shift(8'h00);
        pixel(1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00);
        repeat (2) @(negedge clk28);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
